// File: rtl/bitonic_4_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bitonic_4_loader_pkg
//  Description : Shared defaults, direction encoding and the tag struct that
//                travels alongside each vector through the sorter latency.
//  Revision    : 1.0 - initial release
// ============================================================================
package bitonic_4_loader_pkg;

    localparam int DATAWIDTH_DEF  = 8;
    localparam int DATALENGTH_DEF = 4;

    // Direction tag as seen by the sorter's sign_ctrl input
    localparam logic DIR_ASC  = 1'b0;
    localparam logic DIR_DESC = 1'b1;

    typedef struct packed {
        logic       valid;
        logic       last;
        logic [2:0] count;
    } tag_t;

    localparam int TAG_W = $bits(tag_t);

endpackage
`default_nettype wire

// File: rtl/bitonic_4_loader_tag_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : tag_delay_line
//  Description : Free-running shift register that delays a payload by DEPTH
//                cycles; used to align side-band tags with a fixed-latency
//                datapath. DEPTH = 0 degenerates to a wire.
//  Revision    : 1.0 - initial release
// ============================================================================
module tag_delay_line #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 5
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign q_o = d_i;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage_q [DEPTH];

            // Shift every cycle; the sorter never stalls so neither does this
            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= '0;
                    end
                end else begin
                    stage_q[0] <= d_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign q_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/bitonic_4_loader.sv
`default_nettype none
// ============================================================================
//  Module      : bitonic_4_loader
//  Description : Packs a serial valid/ready element stream into 4-lane
//                vectors for the 4-input bitonic sorter, tags each vector with
//                its sort direction, pads short final groups so pads sort to
//                the high lanes, and delays {valid,last,count} to line up with
//                the sorter output.
//  Revision    : 1.0 - initial release
// ============================================================================
module bitonic_4_loader
    import bitonic_4_loader_pkg::*;
#(
    parameter int DATAWIDTH    = DATAWIDTH_DEF,
    parameter int DATALENGTH   = DATALENGTH_DEF,  // lane counter assumes 4
    parameter int SORT_LATENCY = 3,
    parameter bit ALT_DIR      = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [DATAWIDTH-1:0] in_data_i,
    input  logic                 in_last_i,
    input  logic                 dir_i,
    output logic [DATAWIDTH-1:0] x_o [DATALENGTH],
    output logic                 sign_ctrl_o,
    output logic                 vec_valid_o,
    output logic                 vec_last_o,
    output logic                 out_valid_o,
    output logic                 out_last_o,
    output logic [2:0]           out_count_o
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                 ready_q;
    logic [1:0]           lane_q;
    logic                 frame_start_q;
    logic                 grp_dir_q;
    logic [DATAWIDTH-1:0] buf_q [DATALENGTH];
    logic [DATAWIDTH-1:0] x_q   [DATALENGTH];
    logic                 sign_q;
    logic                 vec_valid_q;
    logic                 vec_last_q;
    logic [2:0]           count_q;

    // ------------------------------------------------------------------
    // Next-state helpers
    // ------------------------------------------------------------------
    logic                 accept_d;
    logic                 close_d;
    logic                 cur_dir_d;
    logic [DATAWIDTH-1:0] pad_d;
    logic [DATAWIDTH-1:0] x_d   [DATALENGTH];
    tag_t                 tag_in_d;
    tag_t                 tag_out_d;

    // Decide acceptance, group closure, group direction and the outgoing vector
    always_comb begin
        accept_d = in_valid_i & ready_q;
        close_d  = accept_d & ((lane_q == 2'd3) | in_last_i);

        // A new frame restarts from dir_i; later group starts optionally flip
        if (frame_start_q) begin
            cur_dir_d = dir_i;
        end else if ((lane_q == 2'd0) && ALT_DIR) begin
            cur_dir_d = ~grp_dir_q;
        end else begin
            cur_dir_d = grp_dir_q;
        end

        // Pads must land at the high lanes after sorting in either direction
        pad_d = (cur_dir_d == DIR_DESC) ? '0 : '1;

        for (int i = 0; i < DATALENGTH; i++) begin
            if (2'(i) < lane_q) begin
                x_d[i] = buf_q[i];
            end else if (2'(i) == lane_q) begin
                x_d[i] = in_data_i;
            end else begin
                x_d[i] = pad_d;
            end
        end
    end

    // Handshake, lane gathering, direction tracking and vector emission
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ready_q       <= 1'b0;
            lane_q        <= 2'd0;
            frame_start_q <= 1'b1;
            grp_dir_q     <= 1'b0;
            sign_q        <= 1'b0;
            vec_valid_q   <= 1'b0;
            vec_last_q    <= 1'b0;
            count_q       <= 3'd0;
            for (int i = 0; i < DATALENGTH; i++) begin
                buf_q[i] <= '0;
                x_q[i]   <= '0;
            end
        end else begin
            ready_q     <= 1'b1;
            vec_valid_q <= close_d;
            vec_last_q  <= close_d & in_last_i;

            if (accept_d) begin
                buf_q[lane_q] <= in_data_i;
                grp_dir_q     <= cur_dir_d;
                frame_start_q <= in_last_i;
                lane_q        <= close_d ? 2'd0 : lane_q + 2'd1;
            end

            if (close_d) begin
                x_q     <= x_d;
                sign_q  <= cur_dir_d;
                count_q <= {1'b0, lane_q} + 3'd1;
            end
        end
    end

    // Count only means something alongside valid; keep idle tags all-zero
    always_comb begin
        tag_in_d.valid = vec_valid_q;
        tag_in_d.last  = vec_last_q;
        tag_in_d.count = vec_valid_q ? count_q : 3'd0;
    end

    tag_delay_line #(
        .DEPTH (SORT_LATENCY),
        .WIDTH (TAG_W)
    ) u_tag_delay_line (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .d_i    (tag_in_d),
        .q_o    (tag_out_d)
    );

    assign in_ready_o  = ready_q;
    assign x_o         = x_q;
    assign sign_ctrl_o = sign_q;
    assign vec_valid_o = vec_valid_q;
    assign vec_last_o  = vec_last_q;
    assign out_valid_o = tag_out_d.valid;
    assign out_last_o  = tag_out_d.last;
    assign out_count_o = tag_out_d.count;

endmodule
`default_nettype wire

// File: tb/tb_bitonic_4_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bitonic_4_loader
//  Description : Self-checking bench: frame-level reference model plus
//                directed literal checks and randomized frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bitonic_4_loader;
    import bitonic_4_loader_pkg::*;

    localparam int DW  = 8;
    localparam int DL  = 4;
    localparam int LAT = 3;
    localparam bit ALT = 1'b1;

    logic          clk_i      = 1'b0;
    logic          rstn_i     = 1'b0;
    logic          in_valid_i = 1'b0;
    logic          in_last_i  = 1'b0;
    logic          dir_i      = 1'b0;
    logic [DW-1:0] in_data_i  = '0;
    logic          in_ready_o;
    logic [DW-1:0] x_o [DL];
    logic          sign_ctrl_o, vec_valid_o, vec_last_o;
    logic          out_valid_o, out_last_o;
    logic [2:0]    out_count_o;

    always #5 clk_i = ~clk_i;

    bitonic_4_loader #(
        .DATAWIDTH    (DW),
        .DATALENGTH   (DL),
        .SORT_LATENCY (LAT),
        .ALT_DIR      (ALT)
    ) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_last_i   (in_last_i),
        .dir_i       (dir_i),
        .x_o         (x_o),
        .sign_ctrl_o (sign_ctrl_o),
        .vec_valid_o (vec_valid_o),
        .vec_last_o  (vec_last_o),
        .out_valid_o (out_valid_o),
        .out_last_o  (out_last_o),
        .out_count_o (out_count_o)
    );

    typedef struct packed {
        logic [3:0][DW-1:0] x;
        logic               sign;
        logic               last;
        logic [2:0]         cnt;
    } exp_t;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h time=%0t", name, act, req, $time);
        end
    endtask

    // Cycle index: posedge k sits at 10k-5; the following negedge maps to k too
    function automatic int cyc_now();
        return int'(($time + 5) / 10);
    endfunction

    // ------------------------------------------------------------------
    // Reference model: groups of up to 4 per frame, direction = frame
    // direction XOR (group parity when alternating), short groups padded.
    // ------------------------------------------------------------------
    exp_t          exp_vec [int];
    exp_t          exp_out [int];
    logic [DW-1:0] grp [$];
    bit            rdy_m    = 1'b0;
    bit            in_frame = 1'b0;
    bit            base_dir = 1'b0;
    int            gidx     = 0;
    exp_t          m_e;

    always @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rdy_m    = 1'b0;
            in_frame = 1'b0;
            gidx     = 0;
            grp.delete();
            exp_vec.delete();
            exp_out.delete();
        end else begin
            if (in_valid_i && rdy_m) begin
                if (grp.size() == 0) begin
                    if (!in_frame) begin
                        in_frame = 1'b1;
                        base_dir = dir_i;
                        gidx     = 0;
                    end else begin
                        gidx++;
                    end
                end
                grp.push_back(in_data_i);
                if (grp.size() == 4 || in_last_i) begin
                    m_e.sign = ALT ? (base_dir ^ gidx[0]) : base_dir;
                    for (int i = 0; i < 4; i++) begin
                        m_e.x[i] = (i < grp.size()) ? grp[i] : (m_e.sign ? 8'h00 : 8'hFF);
                    end
                    m_e.last = in_last_i;
                    m_e.cnt  = 3'(grp.size());
                    exp_vec[cyc_now()]       = m_e;
                    exp_out[cyc_now() + LAT] = m_e;
                    grp.delete();
                    if (in_last_i) in_frame = 1'b0;
                end
            end
            rdy_m = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Compare process: every cycle against the model
    // ------------------------------------------------------------------
    logic [3:0][DW-1:0] hold_x    = '0;
    logic               hold_sign = 1'b0;
    int                 chk_c;
    exp_t               chk_e;

    always @(negedge clk_i) begin
        chk_c = cyc_now();
        if (!rstn_i) begin
            hold_x    = '0;
            hold_sign = 1'b0;
        end
        chk("in_ready", in_ready_o, rdy_m);
        if (exp_vec.exists(chk_c)) begin
            chk_e = exp_vec[chk_c];
            chk("vec_valid", vec_valid_o, 1);
            chk("vec_last", vec_last_o, chk_e.last);
            chk("sign_ctrl", sign_ctrl_o, chk_e.sign);
            for (int i = 0; i < DL; i++) chk($sformatf("x_lane%0d", i), x_o[i], chk_e.x[i]);
            hold_x    = chk_e.x;
            hold_sign = chk_e.sign;
            exp_vec.delete(chk_c);
        end else begin
            chk("vec_valid_idle", vec_valid_o, 0);
            chk("vec_last_idle", vec_last_o, 0);
            chk("sign_hold", sign_ctrl_o, hold_sign);
            for (int i = 0; i < DL; i++) chk($sformatf("x_hold%0d", i), x_o[i], hold_x[i]);
        end
        if (exp_out.exists(chk_c)) begin
            chk_e = exp_out[chk_c];
            chk("out_valid", out_valid_o, 1);
            chk("out_last", out_last_o, chk_e.last);
            chk("out_count", out_count_o, chk_e.cnt);
            exp_out.delete(chk_c);
        end else begin
            chk("out_valid_idle", out_valid_o, 0);
            chk("out_last_idle", out_last_o, 0);
            chk("out_count_idle", out_count_o, 0);
        end
    end

    // ------------------------------------------------------------------
    // Drivers and literal checks
    // ------------------------------------------------------------------
    logic [DW-1:0] fr [32];

    task automatic send_frame(input int n, input logic dir, input bit gaps, input bit with_last);
        for (int i = 0; i < n; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = fr[i];
            in_last_i  = with_last && (i == n - 1);
            dir_i      = dir;
            @(posedge clk_i); #1;
            in_valid_i = 1'b0;
            in_last_i  = 1'b0;
            dir_i      = 1'($urandom);
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                repeat ($urandom_range(1, 3)) @(posedge clk_i);
                #1;
            end
        end
    endtask

    task automatic expect_vec(input int l0, input int l1, input int l2, input int l3,
                              input logic sign, input int cnt);
        bit seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk_i);
            seen = vec_valid_o;
        end
        chk("lit_vec_seen", seen, 1);
        if (seen) begin
            chk("lit_x0", x_o[0], l0);
            chk("lit_x1", x_o[1], l1);
            chk("lit_x2", x_o[2], l2);
            chk("lit_x3", x_o[3], l3);
            chk("lit_sign", sign_ctrl_o, sign);
            chk("lit_last", vec_last_o, 1);
            repeat (LAT) @(negedge clk_i);
            chk("lit_out_valid", out_valid_o, 1);
            chk("lit_out_last", out_last_o, 1);
            chk("lit_out_count", out_count_o, cnt);
        end
    endtask

    task automatic reset_pulse();
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        rstn_i     = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rstn_i = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        #1 rstn_i = 1'b1;
        chk("lit_ready_pre", in_ready_o, 0);
        // Offered while not ready: must be ignored
        in_valid_i = 1'b1; in_data_i = 8'hAA; in_last_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0; in_last_i = 1'b0;
        chk("lit_ready_post", in_ready_o, 1);

        fr[0] = 8; fr[1] = 3; fr[2] = 5; fr[3] = 1;
        send_frame(4, 1'b1, 1'b0, 1'b1);
        expect_vec(8, 3, 5, 1, 1'b1, 4);

        for (int i = 0; i < 8; i++) fr[i] = 8'(i);
        send_frame(8, 1'b0, 1'b0, 1'b1);
        expect_vec(4, 5, 6, 7, 1'b1, 4);

        fr[0] = 9; fr[1] = 4;
        send_frame(2, 1'b1, 1'b0, 1'b1);
        expect_vec(9, 4, 0, 0, 1'b1, 2);
        send_frame(2, 1'b0, 1'b0, 1'b1);
        expect_vec(9, 4, 255, 255, 1'b0, 2);

        fr[0] = 8'h42;
        send_frame(1, 1'b0, 1'b0, 1'b1);
        expect_vec(8'h42, 255, 255, 255, 1'b0, 1);

        // Two frames back-to-back, both descending: second restarts at 1
        for (int i = 0; i < 8; i++) fr[i] = 8'(8'h10 + i);
        send_frame(8, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) fr[i] = 8'(8'h30 + i);
        send_frame(4, 1'b1, 1'b0, 1'b1);
        expect_vec(8'h30, 8'h31, 8'h32, 8'h33, 1'b1, 4);

        // Reset mid-frame discards the partial group
        fr[0] = 10; fr[1] = 11;
        send_frame(2, 1'b1, 1'b0, 1'b0);
        reset_pulse();
        chk("lit_rst_vec_valid", vec_valid_o, 0);
        chk("lit_rst_out_valid", out_valid_o, 0);
        chk("lit_rst_out_count", out_count_o, 0);
        @(posedge clk_i); #1;
        fr[0] = 20; fr[1] = 21; fr[2] = 22; fr[3] = 23;
        send_frame(4, 1'b0, 1'b0, 1'b1);
        expect_vec(20, 21, 22, 23, 1'b0, 4);

        // Randomized frames with occasional gaps and mid-frame resets
        for (int f = 0; f < 40; f++) begin
            int n;
            n = $urandom_range(1, 10);
            for (int i = 0; i < n; i++) fr[i] = 8'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                send_frame(n, 1'($urandom), 1'b1, 1'b0);
                reset_pulse();
            end else begin
                send_frame(n, 1'($urandom), 1'($urandom), 1'b1);
            end
        end
        repeat (LAT + 4) @(posedge clk_i);
        @(negedge clk_i);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/bitonic_4_loader.md
Name: bitonic_4_loader

Overview:
Upstream packer for the 4-input bitonic sorter. It accepts a serial element stream with a valid/ready handshake and gathers it into 4-lane vectors. Each vector is tagged with its sort direction, and a partial final group is padded. In parallel it runs a tag delay line matched to the sorter latency, so downstream logic gets valid, last and count aligned with the sorted output.

Parameters:
DATAWIDTH, 8, element width in bits (unsigned)
DATALENGTH, 4, lanes per vector; fixed at 4 for this block
SORT_LATENCY, 3, sorter pipeline depth in cycles (one per compare-and-swap stage)
ALT_DIR, 1, 1 = direction inverts on each successive group within a frame (feeds an 8-input merge pair); 0 = whole frame uses one direction

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
in_valid_i  in  1  input element valid
in_ready_o  out  1  loader can accept an element
in_data_i  in  DATAWIDTH  input element
in_last_i  in  1  final element of the frame
dir_i  in  1  frame sort direction (1 = descending, largest at lane 0; 0 = ascending); sampled on the first accepted element of a frame
x_o  out  DATAWIDTH x DATALENGTH (unpacked)  vector to the sorter x_i
sign_ctrl_o  out  1  direction tag to the sorter sign_ctrl_i
vec_valid_o  out  1  one-cycle pulse when x_o carries a new group
vec_last_o  out  1  group is the frame's last; qualified by vec_valid_o
out_valid_o  out  1  vec_valid_o delayed by SORT_LATENCY
out_last_o  out  1  vec_last_o delayed by SORT_LATENCY
out_count_o  out  3  non-pad elements in the group (1..4), delayed by SORT_LATENCY

Behaviour:
- Reset (asynchronous, rstn_i low): all outputs 0, x_o lanes 0, lane counter 0, frame_start = 1, delay line cleared.
- in_ready_o is 0 while in reset and 1 from the first clock edge after release. The block never back-pressures after that, because the sorter has no stall.
- accept = in_valid_i & in_ready_o.
- lane_cnt (2 bits) selects the lane register written on accept.
- If accept and (lane_cnt == 3 or in_last_i): on the next cycle, x_o = buffered lanes, with in_data_i in lane lane_cnt. Lanes above lane_cnt take the pad value. vec_valid_o = 1 for that cycle, vec_last_o = in_last_i, and lane_cnt returns to 0.
- Otherwise, on accept, lane_cnt increments.
- Latency from accepting the 4th (or last) element to vec_valid_o is 1 cycle.
- x_o and sign_ctrl_o hold their values between pulses.
- Pad value is 0 when the group direction is 1 and all-ones when it is 0, so pads sort to the high lane indices.
- A full group that is also last (lane_cnt == 3 and in_last_i) is emitted with no pads and vec_last_o = 1.
- A single-element frame emits 1 real element and 3 pads, with count 1.
- Direction: frame_start is set by reset and by any accepted last element.
  - On the first accept while frame_start = 1: grp_dir takes dir_i and frame_start clears.
  - Each later group start: grp_dir toggles if ALT_DIR = 1, otherwise it holds.
  - The next frame restarts from dir_i.
  - sign_ctrl_o = grp_dir of the emitted group.
- Group count = lane_cnt + 1 at emission.
- Delay line: a SORT_LATENCY-deep shift register of {valid, last, count} advances every cycle. out_* is the tail of that shift register.
- Back-to-back groups (an element accepted every cycle) give a vec_valid_o pulse every 4 cycles with no bubbles.
- Reset mid-frame discards the partial group and all in-flight tags.

Decomposition:
- Shared package: DATAWIDTH and DATALENGTH defaults, dir encoding constants (DIR_ASC = 0, DIR_DESC = 1), and a tag struct {valid, last, count[2:0]}.
- Sub-module tag_delay_line, parameterised by depth and payload width; it is reused for any sorter-latency alignment.

Test Plan:
- Reset, then stream 8,3,5,1 (dir_i = 1, last on 1): in_ready_o = 1 one cycle after reset release; one cycle after the 4th accept, x_o = {8,3,5,1}, sign_ctrl_o = 1, vec_valid_o and vec_last_o pulse; 3 cycles later out_valid_o = 1, out_last_o = 1, out_count_o = 4.
- Stream 0..7 every cycle, ALT_DIR = 1, dir_i = 0, last on 7: two pulses 4 cycles apart; sign_ctrl_o = 0 then 1; only the second pulse has vec_last_o = 1.
- Frame 9,4 with last on 4, dir_i = 1: x_o = {9,4,0,0}, out_count_o = 2. Same frame with dir_i = 0: x_o = {9,4,255,255}.
- Single element 0x42, last, dir_i = 0: x_o = {0x42,FF,FF,FF}, out_count_o = 1.
- Two frames back-to-back, ALT_DIR = 1, dir_i = 1 for both: the second frame's first group has sign_ctrl_o = 1 again (direction restarts per frame).
- Assert reset after 2 accepts: no vec_valid_o, all out_* = 0; the next 4 accepts form a clean group starting at lane 0.
